// File: rtl/input_unit_pkg.sv
// Shared router definitions used by the input unit: flit field widths, port count and info codes.
package input_unit_pkg;

   localparam int ROUTER_INFO_WIDTH = 3;
   localparam int ROUTER_ADDR_WIDTH = 8;
   localparam int DIRECTION         = 5;

   typedef enum logic [ROUTER_INFO_WIDTH-1:0] {
      INFO_DATA  = 3'd0,
      INFO_CALC  = 3'd1,
      INFO_WRITE = 3'd2,
      INFO_READ  = 3'd3
   } router_info_e;

   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/input_fifo.sv
// Flit FIFO for one router input port: storage, wrap-bit pointers, full/empty and occupancy.
module input_fifo
   import input_unit_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_push,
   input  logic [WIDTH-1:0]            i_data,
   input  logic                        i_pop,
   output logic                        o_full,
   output logic                        o_empty,
   output logic [WIDTH-1:0]            o_head,
   output logic [ptr_width(DEPTH)-1:0] o_occupancy
);

   localparam int PW = ptr_width(DEPTH);
   localparam int AW = PW - 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic             w_do_push;
   logic             w_do_pop;

   // Pointers carry an extra wrap bit so full and empty are distinguishable.
   assign o_empty     = (r_wr_ptr == r_rd_ptr);
   assign o_full      = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
   assign o_occupancy = r_wr_ptr - r_rd_ptr;
   assign o_head      = r_mem[r_rd_ptr[AW-1:0]];
   assign w_do_push   = i_push && !o_full;
   assign w_do_pop    = i_pop && !o_empty;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // NOTE: storage has no reset; entries are only visible between the pointers, so stale data is harmless.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/input_unit.sv
// Router input port: FIFO, head decode, multicast grant tracking and unroutable-flit drop.
// Optional drop counter output enabled by defining INPUT_UNIT_DROP_CNT_EN.
module input_unit
   import input_unit_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int FLIT_WIDTH = 64
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   input  logic [FLIT_WIDTH-1:0]        in_data,
   output logic                         in_ready,
   output logic                         rc_en,
   output logic [ROUTER_INFO_WIDTH-1:0] route_info,
   output logic [ROUTER_ADDR_WIDTH-1:0] route_addr,
   input  logic [DIRECTION-1:0]         route_port,
   output logic [DIRECTION-1:0]         sa_req,
   input  logic [DIRECTION-1:0]         sa_grant,
   output logic [FLIT_WIDTH-1:0]        out_data,
   output logic                         out_pop,
   output logic                         drop,
`ifdef INPUT_UNIT_DROP_CNT_EN
   output logic [$clog2(DEPTH):0]       occupancy,
   output logic [15:0]                  drop_cnt
`else
   output logic [$clog2(DEPTH):0]       occupancy
`endif
);

   localparam int INFO_MSB = FLIT_WIDTH - 1;
   localparam int INFO_LSB = INFO_MSB - ROUTER_INFO_WIDTH + 1;
   localparam int ADDR_MSB = INFO_LSB - 1;
   localparam int ADDR_LSB = ADDR_MSB - ROUTER_ADDR_WIDTH + 1;

   logic                  w_full;
   logic                  w_empty;
   logic [FLIT_WIDTH-1:0] w_head;
   logic [DIRECTION-1:0]  w_grant;
   logic                  w_unroutable;
   logic                  w_retire;
   logic [DIRECTION-1:0]  r_served;

   input_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (FLIT_WIDTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push      (in_valid),
      .i_data      (in_data),
      .i_pop       (w_retire),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_head      (w_head),
      .o_occupancy (occupancy)
   );

   assign in_ready   = !w_full;
   assign rc_en      = !w_empty;
   assign route_info = w_head[INFO_MSB:INFO_LSB];
   assign route_addr = w_head[ADDR_MSB:ADDR_LSB];
   assign out_data   = w_head;

   // Only outputs still owed to the head are requested; stray grants are masked off.
   assign sa_req       = rc_en ? (route_port & ~r_served) : '0;
   assign w_grant      = sa_grant & sa_req;
   assign w_unroutable = (route_port == '0);
   assign out_pop      = rc_en && !w_unroutable && ((r_served | w_grant) == route_port);
   assign drop         = rc_en && w_unroutable;
   assign w_retire     = out_pop || drop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           r_served <= '0;
      else if (w_retire) r_served <= '0;
      else               r_served <= r_served | w_grant;
   end

`ifdef INPUT_UNIT_DROP_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                           drop_cnt <= '0;
      else if (drop && drop_cnt != '1)   drop_cnt <= drop_cnt + 16'd1;
   end
`else
   // Without the counter, drop is still reported on its own output.
`endif

endmodule

// File: tb/tb_input_unit.sv
// Directed self-checking bench for input_unit (DEPTH=4, 64-bit flits).
module tb_input_unit;
   import input_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [63:0] in_data;
   logic        in_ready;
   logic        rc_en;
   logic [2:0]  route_info;
   logic [7:0]  route_addr;
   logic [4:0]  route_port;
   logic [4:0]  sa_req;
   logic [4:0]  sa_grant;
   logic [63:0] out_data;
   logic        out_pop;
   logic        drop;
   logic [2:0]  occupancy;
`ifdef INPUT_UNIT_DROP_CNT_EN
   logic [15:0] drop_cnt;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   input_unit #(.DEPTH(4), .FLIT_WIDTH(64)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .rc_en      (rc_en),
      .route_info (route_info),
      .route_addr (route_addr),
      .route_port (route_port),
      .sa_req     (sa_req),
      .sa_grant   (sa_grant),
      .out_data   (out_data),
      .out_pop    (out_pop),
      .drop       (drop),
`ifdef INPUT_UNIT_DROP_CNT_EN
      .occupancy  (occupancy),
      .drop_cnt   (drop_cnt)
`else
      .occupancy  (occupancy)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Advance to just after the next rising edge; inputs change and outputs are sampled here.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] flit(input logic [2:0] info, input logic [7:0] addr,
                                        input logic [52:0] payload);
      return {info, addr, payload};
   endfunction

   logic [63:0] f_calc;
   logic [63:0] fl [5];

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; route_port = '0; sa_grant = '0;
      step();
      step();
      rst = 1'b0;
      #1;
      check("reset_in_ready", 64'(in_ready), 64'd1);
      check("reset_rc_en",    64'(rc_en),    64'd0);
      check("reset_sa_req",   64'(sa_req),   64'd0);
      check("reset_out_pop",  64'(out_pop),  64'd0);
      check("reset_drop",     64'(drop),     64'd0);
      check("reset_occ",      64'(occupancy), 64'd0);

      // Multicast 01111 granted in two pieces.
      f_calc = flit(INFO_CALC, 8'h12, 53'h1234);
      in_valid = 1'b1; in_data = f_calc; route_port = 5'b01111;
      #1;
      check("no_bypass_rc_en", 64'(rc_en), 64'd0);
      step();
      in_valid = 1'b0;
      #1;
      check("mc_rc_en",  64'(rc_en),      64'd1);
      check("mc_occ",    64'(occupancy),  64'd1);
      check("mc_sa_req", 64'(sa_req),     64'h0f);
      check("mc_info",   64'(route_info), 64'(INFO_CALC));
      check("mc_addr",   64'(route_addr), 64'h12);
      sa_grant = 5'b00011;
      #1;
      check("mc_first_no_pop", 64'(out_pop), 64'd0);
      step();
      sa_grant = 5'b01100;
      #1;
      check("mc_sa_req_rest", 64'(sa_req),  64'h0c);
      check("mc_pop",         64'(out_pop), 64'd1);
      check("mc_out_data",    out_data,     f_calc);
      step();
      sa_grant = '0;
      #1;
      check("mc_occ_after", 64'(occupancy), 64'd0);
      check("mc_rc_en_after", 64'(rc_en), 64'd0);

      // Fill to DEPTH, reject an extra push, drain in order.
      route_port = 5'b10000;
      for (int i = 0; i < 4; i++) begin
         fl[i] = flit(INFO_DATA, 8'(i), 53'(16'hA000 + i));
         in_valid = 1'b1; in_data = fl[i];
         step();
      end
      in_data = flit(INFO_DATA, 8'hFF, 53'hDEAD);
      #1;
      check("full_in_ready", 64'(in_ready),  64'd0);
      check("full_occ",      64'(occupancy), 64'd4);
      step();
      in_valid = 1'b0;
      #1;
      check("full_no_extra", 64'(occupancy), 64'd4);
      for (int i = 0; i < 4; i++) begin
         sa_grant = 5'b10000;
         #1;
         check("drain_pop",  64'(out_pop), 64'd1);
         check("drain_data", out_data,     fl[i]);
         step();
      end
      sa_grant = '0;
      #1;
      check("drain_empty", 64'(occupancy), 64'd0);

      // Unroutable head is dropped while the next flit is pushed.
      fl[0] = flit(INFO_DATA, 8'h01, 53'hB0);
      fl[1] = flit(INFO_DATA, 8'h02, 53'hB1);
      in_valid = 1'b1; in_data = fl[0];
      step();
      in_data = fl[1]; route_port = '0;
      #1;
      check("drop_pulse", 64'(drop),    64'd1);
      check("drop_no_pop", 64'(out_pop), 64'd0);
      step();
      in_valid = 1'b0; route_port = 5'b00001;
      #1;
      check("drop_cleared",   64'(drop),      64'd0);
      check("drop_next_head", out_data,       fl[1]);
      check("drop_occ",       64'(occupancy), 64'd1);
`ifdef INPUT_UNIT_DROP_CNT_EN
      check("drop_cnt", 64'(drop_cnt), 64'd1);
`endif
      sa_grant = 5'b00001;
      step();
      sa_grant = '0;
      #1;
      check("drop_drain", 64'(occupancy), 64'd0);

      // Spurious grant outside the request is ignored.
      in_valid = 1'b1; in_data = flit(INFO_READ, 8'h33, 53'hC0); route_port = 5'b00100;
      step();
      in_valid = 1'b0; sa_grant = 5'b10000;
      #1;
      check("spur_sa_req", 64'(sa_req),  64'h04);
      check("spur_no_pop", 64'(out_pop), 64'd0);
      step();
      sa_grant = '0;
      #1;
      check("spur_served_kept", 64'(sa_req),    64'h04);
      check("spur_occ",         64'(occupancy), 64'd1);
      sa_grant = 5'b00100;
      #1;
      check("spur_real_pop", 64'(out_pop), 64'd1);
      step();
      sa_grant = '0;
      #1;
      check("spur_empty", 64'(occupancy), 64'd0);

      // Full FIFO: pop and in_valid together must not push.
      route_port = 5'b00010;
      for (int i = 0; i < 4; i++) begin
         fl[i] = flit(INFO_WRITE, 8'(8'h40 + i), 53'(16'hD000 + i));
         in_valid = 1'b1; in_data = fl[i];
         step();
      end
      fl[4] = flit(INFO_WRITE, 8'h4F, 53'hEEEE);
      in_data = fl[4]; sa_grant = 5'b00010;
      #1;
      check("fullpop_in_ready", 64'(in_ready), 64'd0);
      check("fullpop_pop",      64'(out_pop),  64'd1);
      step();
      sa_grant = '0;
      #1;
      check("fullpop_occ3",  64'(occupancy), 64'd3);
      check("fullpop_ready", 64'(in_ready),  64'd1);
      step();
      in_valid = 1'b0;
      #1;
      check("fullpop_occ4", 64'(occupancy), 64'd4);
      for (int i = 1; i < 5; i++) begin
         sa_grant = 5'b00010;
         #1;
         check("fullpop_order", out_data, fl[i]);
         step();
      end
      sa_grant = '0;
      #1;
      check("fullpop_empty", 64'(occupancy), 64'd0);

      // Asynchronous reset after a partial multicast grant.
      in_valid = 1'b1; in_data = flit(INFO_CALC, 8'h77, 53'hF0); route_port = 5'b01111;
      step();
      in_valid = 1'b0; sa_grant = 5'b00001;
      step();
      sa_grant = '0;
      #1;
      check("pre_rst_sa_req", 64'(sa_req), 64'h0e);
      #1;
      rst = 1'b1;
      #1;
      check("async_rst_rc_en",    64'(rc_en),     64'd0);
      check("async_rst_occ",      64'(occupancy), 64'd0);
      check("async_rst_sa_req",   64'(sa_req),    64'd0);
      check("async_rst_in_ready", 64'(in_ready),  64'd1);
      step();
      rst = 1'b0;
      step();
      check("post_rst_idle", 64'(rc_en), 64'd0);
      f_calc = flit(INFO_CALC, 8'h78, 53'hF1);
      in_valid = 1'b1; in_data = f_calc;
      step();
      in_valid = 1'b0;
      #1;
      check("post_rst_full_req", 64'(sa_req), 64'h0f);
      sa_grant = 5'b01110;
      #1;
      check("post_rst_no_pop", 64'(out_pop), 64'd0);
      step();
      sa_grant = 5'b00001;
      #1;
      check("post_rst_pop", 64'(out_pop), 64'd1);
      step();
      sa_grant = '0;
      #1;
      check("post_rst_empty", 64'(occupancy), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/input_unit.md
# input_unit

Per-port input stage of the quadtree router. Buffers incoming flits in a small FIFO, presents the head flit's routing fields to the port's RoutingComputer, and holds the returned `route_port` vector as a multicast request to the switch allocator. Pops the head only after every requested output has granted. Sits between the link (or local PE/root controller) input and the switch allocator; one instance per router port.

## Interface
Parameters:
- `DEPTH`, 4: FIFO depth in flits; power of two, ≥2.
- `FLIT_WIDTH`, 64: flit width. Layout is {info[`ROUTER_INFO_WIDTH`], addr[`ROUTER_ADDR_WIDTH`], payload}, MSB first.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `in_valid`  in  1  upstream flit valid.
- `in_data`  in  FLIT_WIDTH  upstream flit.
- `in_ready`  out  1  FIFO can accept; equals !full.
- `rc_en`  out  1  head flit valid (FIFO non-empty).
- `route_info`  out  `ROUTER_INFO_WIDTH`  head info field.
- `route_addr`  out  `ROUTER_ADDR_WIDTH`  head addr field.
- `route_port`  in  `DIRECTION`  routing result from RoutingComputer, combinational from the three outputs above.
- `sa_req`  out  `DIRECTION`  outstanding output requests for the head flit.
- `sa_grant`  in  `DIRECTION`  switch-allocator grants, one cycle each.
- `out_data`  out  FLIT_WIDTH  head flit, forwarded to the crossbar.
- `out_pop`  out  1  head retired this cycle.
- `drop`  out  1  head discarded this cycle (`route_port` == 0).
- `occupancy`  out  $clog2(DEPTH)+1  flits stored.

## Operation
- FIFO: write/read pointers of $clog2(DEPTH)+1 bits, with the MSB used as the wrap bit. Empty: pointers equal. Full: low bits equal, MSB differs. Pointers wrap naturally modulo 2·DEPTH.
- Push when `in_valid && in_ready`. `in_ready` = !full and does not depend on a same-cycle pop. Full with a pop does not accept a push.
- `rc_en` = !empty. `route_info`, `route_addr`, `out_data` are decoded from the head entry and are don't-care when empty.
- `served` register (`DIRECTION` bits) records outputs already granted for the current head.
- `sa_req` = rc_en ? (route_port & ~served) : 0.
- Effective grant `g` = `sa_grant & sa_req`. Grant bits outside `sa_req` are ignored.
- If (served | g) == route_port and route_port != 0: `out_pop`=1, read pointer advances, `served` clears.
- Otherwise `served` |= g.
- If rc_en and route_port == 0, the head is unroutable: pulse `drop`=1 and `out_pop`=0, advance the read pointer, and clear `served`. This takes one cycle per dropped flit.
- Multicast (e.g. 5'b01111) may be granted piecewise across cycles or all at once. Retirement occurs in the cycle the final grant arrives.
- Pushes and pops/drops in the same cycle update `occupancy` by net 0.

## Timing
- Reset values: both pointers 0, `served` 0. Consequently `in_ready`=1, `rc_en`=0, `sa_req`=0, `out_pop`=0, `drop`=0, `occupancy`=0.
- Reset asserted mid-multicast discards all stored flits and partial grants. No flit is emitted after reset deasserts until a new push.
- Latency: a flit pushed in cycle N is at the head (`rc_en`, `sa_req` valid) in cycle N+1 when the FIFO was empty. There is no bypass.
- `sa_req`, `out_pop`, `drop` are combinational from registered state plus `route_port`/`sa_grant`. The allocator must not make `sa_grant` depend combinationally on `out_pop`.
- Back-to-back retirement: one flit per cycle maximum.

## Configuration
- `INPUT_UNIT_DROP_CNT_EN` defined: adds output `drop_cnt` (16 bits). It resets to 0, increments on each `drop`, and saturates at 16'hFFFF.
- Undefined: port and counter are absent. `drop` behaviour is unchanged.

## Structure
- Flit field offsets (INFO_MSB/LSB, ADDR_MSB/LSB) and `DIRECTION` belong in the shared `router.vh`, beside the existing ROUTER_INFO_* and ROUTER_ADDR_WIDTH definitions.
- One sub-module: `input_fifo`, holding storage, pointers, full/empty, and occupancy. `input_unit` keeps the head decode, `served` tracking, and drop logic. RoutingComputer is instantiated by the router top, not inside this block.

## Test plan
- Reset then push flit with info=CALC and RC returning 5'b01111. Cycle after push: `sa_req`=5'b01111. Grant 5'b00011, then 5'b01100 the next cycle. The second grant cycle gives `out_pop`=1 and `occupancy` 1→0.
- Fill DEPTH=4 without grants: `in_ready`=0 at occupancy 4. Extra `in_valid` is not stored. Single-port grants (5'b10000) drain four flits in four consecutive cycles, in FIFO order.
- Head with RC result 0: `drop`=1 for one cycle, the following flit becomes head next cycle, and `drop_cnt`=1 when the macro is enabled.
- Spurious grant 5'b10000 while `sa_req`=5'b00100: `served` unchanged and no pop. Grant 5'b00100 then pops.
- Full FIFO with a pop and `in_valid` in the same cycle: no push, occupancy 4→3. Push succeeds the next cycle.
- Assert `rst` after a partial grant of 5'b00001 out of 5'b01111: all outputs return to reset values asynchronously. A new flit requires full grants again.
